// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: shared state encoding, collision bit indices and fixed-point helpers
package ball_motion_pkg;
    typedef enum logic [1:0] {REST, CHARGE, ROLL, POCKET} ball_state_e;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;
    localparam int WALL_HORZ   = 1;
    localparam int WALL_VERT   = 0;

    // Arithmetic shift that rounds toward zero instead of toward -inf
    function automatic logic signed [63:0] sra_tz(input logic signed [63:0] v, input int sh);
        return (v < 64'sd0) ? -((-v) >>> sh) : (v >>> sh);
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input logic signed [63:0] lim);
        return (v > lim) ? lim : (v < -lim) ? -lim : v;
    endfunction
endpackage

// File: rtl/ball_axis_integrator.sv
// ball_axis_integrator: one axis of fixed-point position/velocity with friction, reflection and damping
module ball_axis_integrator
    import ball_motion_pkg::*;
#(
    parameter int INIT_POS        = 400,
    parameter int POS_W           = 11,
    parameter int FRAC_BITS       = 6,
    parameter int VEL_W           = 24,
    parameter int FRICTION_SHIFT  = 6,
    parameter int WALL_DAMP_SHIFT = 0,
    parameter int MIN_SPEED       = 2,
    parameter int BOUNCE_SPEED    = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame,
    input  logic                    set,
    input  logic signed [POS_W-1:0] set_pos,
    input  logic                    load,
    input  logic signed [VEL_W-1:0] load_vel,
    input  logic                    wall_hit,
    input  logic                    lo_hit,
    input  logic                    hi_hit,
    output logic signed [POS_W-1:0] pos_px,
    output logic signed [POS_W-1:0] speed,
    output logic                    vel_nz
);
    localparam int PW = POS_W + FRAC_BITS;
    localparam logic signed [63:0] VEL_MAX = (64'sd1 <<< (VEL_W - 1)) - 64'sd1;
    localparam logic signed [63:0] SPD_MAX = (64'sd1 <<< (POS_W - 1)) - 64'sd1;
    localparam logic signed [63:0] BOUNCE  = 64'(BOUNCE_SPEED) <<< FRAC_BITS;
    localparam logic signed [63:0] MIN_SPD = 64'(MIN_SPEED);

    logic signed [PW-1:0]    pos_q, pos_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic signed [63:0]      v, spd, ball_v, hit, fric, fspd;
    logic                    ball_act;

    always_comb begin
        v        = 64'(vel_q);
        spd      = sra_tz(v, FRAC_BITS);
        ball_act = lo_hit || hi_hit;
        ball_v   = ((lo_hit && v < 64'sd0) || (hi_hit && v > 64'sd0)) ? -v :
                   (lo_hit && v == 64'sd0) ? BOUNCE :
                   (hi_hit && v == 64'sd0) ? -BOUNCE : v;
        hit      = !wall_hit ? ball_v :
                   (WALL_DAMP_SHIFT != 0) ? -v - sra_tz(-v, WALL_DAMP_SHIFT) : -v;
        fric     = v - sra_tz(v, FRICTION_SHIFT);
        fspd     = sra_tz(fric, FRAC_BITS);
        if ((fspd <= MIN_SPD && fspd >= -MIN_SPD) || ((fric < 64'sd0) != (v < 64'sd0)))
            fric = 64'sd0;
        // A collision this cycle replaces the friction step for this frame
        vel_d = set ? '0 : load ? load_vel :
                (wall_hit || ball_act) ? VEL_W'(sat(hit, VEL_MAX)) :
                frame ? VEL_W'(fric) : vel_q;
        pos_d = set ? PW'(set_pos) <<< FRAC_BITS : frame ? pos_q + PW'(spd) : pos_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= PW'(INIT_POS) <<< FRAC_BITS;
            vel_q <= '0;
        end else begin
            pos_q <= pos_d;
            vel_q <= vel_d;
        end
    end

    assign pos_px = pos_q[PW-1:FRAC_BITS];
    assign speed  = POS_W'(sat(spd, SPD_MAX));
    assign vel_nz = vel_d != '0;
endmodule

// File: rtl/ball_motion_engine.sv
// ball_motion_engine: per-ball state machine and cue-ball shot charging over two axis integrators.
// Define BALL_POCKET_EN to enable pocket parking and respawn.
module ball_motion_engine
    import ball_motion_pkg::*;
#(
    parameter int INITIAL_X       = 400,
    parameter int INITIAL_Y       = 220,
    parameter int CUE_BALL        = 0,
    parameter int POS_W           = 11,
    parameter int FRAC_BITS       = 6,
    parameter int VEL_W           = 24,
    parameter int FRICTION_SHIFT  = 6,
    parameter int WALL_DAMP_SHIFT = 0,
    parameter int MIN_SPEED       = 2,
    parameter int MAX_SHOT        = 512,
    parameter int SHOT_STEP       = 64,
    parameter int BOUNCE_SPEED    = 128,
    parameter int PARK_X          = 700,
    parameter int PARK_Y          = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    chargeUp,
    input  logic                    chargeDown,
    input  logic                    chargeLeft,
    input  logic                    chargeRight,
    input  logic                    releaseBall,
    input  logic                    collision_with_wall,
    input  logic [1:0]              collided_wall,
    input  logic                    collision_with_ball,
    input  logic [3:0]              HitEdgeCode,
    input  logic                    pocketed,
    input  logic                    respawn,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic signed [POS_W-1:0] XspeedOUT,
    output logic signed [POS_W-1:0] YspeedOUT,
    output logic signed [POS_W-1:0] shotX,
    output logic signed [POS_W-1:0] shotY,
    output logic                    moving,
    output logic                    stopped
);
    ball_state_e             state_q, state_d;
    logic signed [POS_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d, acc_x, acc_y, set_x, set_y;
    logic                    stopped_q, stopped_d;
    logic                    pocket_go, respawn_go, active, fire, vel_nz_x, vel_nz_y;

`ifdef BALL_POCKET_EN
    assign pocket_go  = pocketed && state_q != POCKET;
    assign respawn_go = respawn && state_q == POCKET;
    assign set_x      = pocket_go ? POS_W'(PARK_X) : POS_W'(INITIAL_X);
    assign set_y      = pocket_go ? POS_W'(PARK_Y) : POS_W'(INITIAL_Y);
`else
    logic unused_pocket;
    assign pocket_go     = 1'b0;
    assign respawn_go    = 1'b0;
    assign set_x         = POS_W'(INITIAL_X);
    assign set_y         = POS_W'(INITIAL_Y);
    assign unused_pocket = ^{pocketed, respawn, 32'(PARK_X), 32'(PARK_Y)};
`endif

    assign active = state_q != POCKET && !pocket_go;
    assign fire   = (CUE_BALL != 0) && state_q == CHARGE && releaseBall && active;

    always_comb begin
        acc_x = POS_W'(sat(64'(shot_x_q) + (chargeRight ? 64'(SHOT_STEP) : 64'sd0)
                           - (chargeLeft ? 64'(SHOT_STEP) : 64'sd0), 64'(MAX_SHOT)));
        acc_y = POS_W'(sat(64'(shot_y_q) + (chargeDown ? 64'(SHOT_STEP) : 64'sd0)
                           - (chargeUp ? 64'(SHOT_STEP) : 64'sd0), 64'(MAX_SHOT)));
        state_d   = state_q;
        stopped_d = 1'b0;
        shot_x_d  = shot_x_q;
        shot_y_d  = shot_y_q;
        if (pocket_go) begin
            state_d  = POCKET;
            shot_x_d = '0;
            shot_y_d = '0;
        end else if (respawn_go) begin
            state_d = REST;
        end else if (state_q == ROLL) begin
            state_d   = (vel_nz_x || vel_nz_y) ? ROLL : REST;
            stopped_d = !(vel_nz_x || vel_nz_y);
        end else if (fire) begin
            state_d  = (shot_x_q != '0 || shot_y_q != '0) ? ROLL : REST;
            shot_x_d = '0;
            shot_y_d = '0;
        end else if (active && collision_with_ball && (vel_nz_x || vel_nz_y)) begin
            state_d  = ROLL;
            shot_x_d = '0;
            shot_y_d = '0;
        end else if (active && CUE_BALL != 0) begin
            shot_x_d = acc_x;
            shot_y_d = acc_y;
            if (chargeUp || chargeDown || chargeLeft || chargeRight)
                state_d = CHARGE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= REST;
            shot_x_q  <= '0;
            shot_y_q  <= '0;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shot_x_q  <= shot_x_d;
            shot_y_q  <= shot_y_d;
            stopped_q <= stopped_d;
        end
    end

    ball_axis_integrator #(
        .INIT_POS(INITIAL_X), .POS_W(POS_W), .FRAC_BITS(FRAC_BITS), .VEL_W(VEL_W),
        .FRICTION_SHIFT(FRICTION_SHIFT), .WALL_DAMP_SHIFT(WALL_DAMP_SHIFT),
        .MIN_SPEED(MIN_SPEED), .BOUNCE_SPEED(BOUNCE_SPEED)
    ) u_axis_x (
        .clk(clk), .reset(reset), .frame(startOfFrame),
        .set(pocket_go || respawn_go), .set_pos(set_x),
        .load(fire), .load_vel(VEL_W'(64'(shot_x_q) <<< FRAC_BITS)),
        .wall_hit(active && collision_with_wall && collided_wall[WALL_VERT]),
        .lo_hit(active && collision_with_ball && HitEdgeCode[EDGE_LEFT]),
        .hi_hit(active && collision_with_ball && HitEdgeCode[EDGE_RIGHT]),
        .pos_px(topLeftX), .speed(XspeedOUT), .vel_nz(vel_nz_x)
    );

    ball_axis_integrator #(
        .INIT_POS(INITIAL_Y), .POS_W(POS_W), .FRAC_BITS(FRAC_BITS), .VEL_W(VEL_W),
        .FRICTION_SHIFT(FRICTION_SHIFT), .WALL_DAMP_SHIFT(WALL_DAMP_SHIFT),
        .MIN_SPEED(MIN_SPEED), .BOUNCE_SPEED(BOUNCE_SPEED)
    ) u_axis_y (
        .clk(clk), .reset(reset), .frame(startOfFrame),
        .set(pocket_go || respawn_go), .set_pos(set_y),
        .load(fire), .load_vel(VEL_W'(64'(shot_y_q) <<< FRAC_BITS)),
        .wall_hit(active && collision_with_wall && collided_wall[WALL_HORZ]),
        .lo_hit(active && collision_with_ball && HitEdgeCode[EDGE_TOP]),
        .hi_hit(active && collision_with_ball && HitEdgeCode[EDGE_BOTTOM]),
        .pos_px(topLeftY), .speed(YspeedOUT), .vel_nz(vel_nz_y)
    );

    assign moving  = state_q == ROLL;
    assign stopped = stopped_q;
    assign shotX   = shot_x_q;
    assign shotY   = shot_y_q;
endmodule
